// File: rtl/sipo_register_if.sv
// Serial-in / parallel-out bus between a bit source and sipo_register.
// word_valid exists only when SIPO_WORD_VALID_EN is defined.
interface sipo_register_if #(
  parameter int unsigned WIDTH = 4
);
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
`ifdef SIPO_WORD_VALID_EN
  logic             word_valid;

  modport master (
    output serial_in,
    input  parallel_out,
    input  word_valid
  );

  modport slave (
    input  serial_in,
    output parallel_out,
    output word_valid
  );
`else
  modport master (
    output serial_in,
    input  parallel_out
  );

  modport slave (
    input  serial_in,
    output parallel_out
  );
`endif
endinterface

// File: rtl/sipo_register.sv
// Free-running serial-in / parallel-out shift register with synchronous active-low reset.
// Define SIPO_WORD_VALID_EN to add a bit counter and a one-cycle word_valid pulse.
module sipo_register #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          SHIFT_LEFT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sipo_register_if.slave   bus
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;

  generate
    if (SHIFT_LEFT) begin : g_left
      always_comb begin
        w_data_next = {r_data[WIDTH-2:0], bus.serial_in};
      end
    end else begin : g_right
      always_comb begin
        w_data_next = {bus.serial_in, r_data[WIDTH-1:1]};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_next;
    end
  end

  assign bus.parallel_out = r_data;

`ifdef SIPO_WORD_VALID_EN
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [CntW-1:0] r_cnt;
  logic            r_word_valid;
  logic            w_cnt_wrap;

  // The shift completing a word is the one taken while the count sits at WIDTH-1.
  assign w_cnt_wrap = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      r_word_valid <= w_cnt_wrap;
    end
  end

  assign bus.word_valid = r_word_valid;
`endif

endmodule

// File: tb/tb_sipo_register.sv
// Self-checking bench: a left- and a right-shifting instance share stimulus; a queue-based
// history model predicts both outputs (and word_valid when SIPO_WORD_VALID_EN is defined).
module tb_sipo_register;
  localparam int unsigned W = 4;

  typedef struct {
    logic         rst;
    logic         sin;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
    logic         exp_wv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model: most recent bit at index 0; shifts counted since last reset.
  bit hist[$];
  int n_shifts = 0;

  always #5 clk = ~clk;

  sipo_register_if #(.WIDTH(W)) bus_l ();
  sipo_register_if #(.WIDTH(W)) bus_r ();

  assign bus_l.serial_in = sin;
  assign bus_r.serial_in = sin;

  sipo_register #(.WIDTH(W), .SHIFT_LEFT(1'b1)) u_left (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  sipo_register #(.WIDTH(W), .SHIFT_LEFT(1'b0)) u_right (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  task automatic check_bits(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one edge's worth of inputs and update the model.
  task automatic step(input logic r, input logic s);
    @(negedge clk);
    rst = r;
    sin = s;
    @(posedge clk);
    #1;
    if (!r) begin
      hist.delete();
      n_shifts = 0;
    end else begin
      hist.push_front(s);
      if (hist.size() > W) void'(hist.pop_back());
      n_shifts++;
    end
  endtask

  function automatic logic [W-1:0] model_left();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) if (i < hist.size()) v[i] = hist[i];
    return v;
  endfunction

  function automatic logic [W-1:0] model_right();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) if (i < hist.size()) v[W-1-i] = hist[i];
    return v;
  endfunction

  function automatic logic model_wv();
    return (n_shifts > 0) && (n_shifts % W == 0);
  endfunction

  task automatic check_model(input string tag);
    check_bits({tag, " left"}, bus_l.parallel_out, model_left());
    check_bits({tag, " right"}, bus_r.parallel_out, model_right());
`ifdef SIPO_WORD_VALID_EN
    check_bit({tag, " wv_left"}, bus_l.word_valid, model_wv());
    check_bit({tag, " wv_right"}, bus_r.word_valid, model_wv());
`endif
  endtask

  initial begin
    vec_t vecs[$];
    string tag;

    // Reset, 1011 stream, overflow with zeros, then a mid-word reset.
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b0101, 4'b1010, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b1011, 4'b1101, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 4'b0110, 4'b0110, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b1100, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'b1001, 4'b1001, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].sin);
      tag = $sformatf("vec%0d", i);
      check_bits({tag, " left"}, bus_l.parallel_out, vecs[i].exp_l);
      check_bits({tag, " right"}, bus_r.parallel_out, vecs[i].exp_r);
`ifdef SIPO_WORD_VALID_EN
      check_bit({tag, " wv"}, bus_l.word_valid, vecs[i].exp_wv);
`endif
    end

    // Word framing: 12 continuous shifts after reset.
    step(1'b0, 1'b1);
    check_model("frame_rst");
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      check_model($sformatf("frame_shift%0d", i));
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_register.md
SIPO_REGISTER -- requirements
Module: sipo_register

Interface
REQ-001 Parameter WIDTH, default 4: number of parallel output bits; legal range 2..64.
REQ-002 Parameter SHIFT_LEFT, default 1: 1 = new bit enters at bit 0, shifting toward MSB; 0 = new bit enters at bit WIDTH-1, shifting toward LSB.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 serial_in  input  1  serial data bit, sampled every rising clk edge while not in reset.
REQ-006 parallel_out  output  WIDTH  registered shift-register contents.
REQ-007 word_valid  output  1  registered one-cycle pulse at each completed WIDTH-bit word; present only when SIPO_WORD_VALID_EN is defined.

Function
REQ-008 The block SHALL shift once on every rising clk edge with rst high; there is no enable or hold state.
REQ-009 With SHIFT_LEFT=1, the next parallel_out SHALL be {parallel_out[WIDTH-2:0], serial_in}.
REQ-010 With SHIFT_LEFT=0, the next parallel_out SHALL be {serial_in, parallel_out[WIDTH-1:1]}.
REQ-011 Latency SHALL be one cycle: serial_in sampled at edge N is visible in parallel_out immediately after edge N.
REQ-012 A bit SHALL reach the far end of the register (bit WIDTH-1 for SHIFT_LEFT=1, bit 0 for SHIFT_LEFT=0) after WIDTH edges and be discarded on the next edge.
REQ-013 parallel_out SHALL be driven directly from flops, with no combinational path from serial_in.
REQ-014 An X or Z on serial_in SHALL propagate only into the shifted bit position; the block SHALL contain no other data-dependent logic.

Reset
REQ-015 When rst is low at a rising clk edge, parallel_out SHALL become all zeros, and word_valid (if present) SHALL become 0.
REQ-016 Reset SHALL take priority over shifting; serial_in is ignored on reset edges.
REQ-017 rst SHALL have no asynchronous effect; if rst is deasserted mid-word, the shift restarts from an all-zero register and a zero bit count.
REQ-018 The first shift SHALL occur at the first rising edge at which rst is sampled high.

Configuration
REQ-019 With macro SIPO_WORD_VALID_EN defined, the block SHALL include a bit counter (width clog2(WIDTH)+1) that increments on each shift, and the word_valid port.
REQ-020 With the macro defined, word_valid SHALL be 1 for exactly the cycle after the WIDTH-th shift following reset, when parallel_out holds the complete word; the counter SHALL then wrap to 0 so that the next pulse follows after WIDTH more shifts.
REQ-021 With the macro defined, reset SHALL clear the counter, and the counter SHALL not otherwise affect parallel_out.
REQ-022 Without SIPO_WORD_VALID_EN, the word_valid port and the counter SHALL be absent, and parallel_out behaviour SHALL be identical.

Verification
REQ-023 Reset check: rst=0 for 2 edges with serial_in=1 -> parallel_out=4'b0000 (and word_valid=0 if enabled).
REQ-024 Shift-left check: WIDTH=4, SHIFT_LEFT=1, after reset apply serial 1,0,1,1 on successive edges -> parallel_out = 0001, 0010, 0101, 1011.
REQ-025 Shift-right check: SHIFT_LEFT=0, same stream -> parallel_out = 1000, 0100, 1010, 1101.
REQ-026 Overflow check: continue with 0,0,0,0 -> 0110, 1100, 1000, 0000; the oldest bits are discarded.
REQ-027 Mid-word reset check: after 2 shifts of 1, pull rst low for 1 edge -> parallel_out=0000; with SIPO_WORD_VALID_EN defined, the next word_valid pulse comes only after 4 further shifts.
REQ-028 Word-valid check: SIPO_WORD_VALID_EN defined, 12 continuous shifts after reset -> word_valid is high exactly after shifts 4, 8 and 12, with parallel_out holding the matching 4-bit word each time.
